mem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mem_word_array.sv | 33 +++
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_pkg
//  Brief    : Shared types and constants for the multicycle MIPS memory
//             responder (state encoding, word width, default latency).
//  Revision : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

  localparam int WORD_W              = 32;
  localparam int DEFAULT_MEM_LATENCY = 2;

  // Responder states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // A word access is misaligned when either byte-offset bit is set
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_array
//  Brief    : Single-port DEPTH_WORDS x 32 word storage. Synchronous write
//             with write enable, combinational read at the same index.
//             Contents are not affected by reset.
//  Revision : 1.0  initial release
// ============================================================================
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [WORD_W-1:0]              i_wdata,
  output logic [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] storage_q [DEPTH_WORDS];

  // Store the word on a write strobe; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (i_we) begin
      storage_q[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = storage_q[i_idx];

endmodule : mem_word_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Brief    : Fixed-latency word memory responder for the multicycle MIPS
//             datapath. A captured request waits LATENCY cycles in WAIT,
//             then answers with a one-cycle Ready pulse in RESP. Writes
//             commit on the edge leaving RESP; a Req during RESP is taken
//             back-to-back, a Req during WAIT is dropped and flagged.
//  Options  : MEM_ALIGN_CHECK_EN - when defined, a misaligned address sets
//             AddrErr in RESP, suppresses the write and zeroes read data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = DEFAULT_MEM_LATENCY
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr,
  output logic        ReqDropped
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IDX_W+1:0]  addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_dropped_q, req_dropped_d;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_mem_rdata;
  logic              w_unused_addr;

  // Word index comes from the captured address; upper bits alias
  assign w_idx = addr_q[IDX_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned  = is_misaligned(addr_q[1:0]);
  assign w_unused_addr = &{1'b0, Address[WORD_W-1:IDX_W+2]};
`else
  assign w_misaligned  = 1'b0;
  assign w_unused_addr = &{1'b0, Address[WORD_W-1:IDX_W+2], addr_q[1:0]};
`endif

  // A new request is taken when idle, or in the response cycle (back-to-back)
  assign w_accept = Req && ((state_q == MEM_IDLE) || (state_q == MEM_RESP));

  // Commit on the edge leaving RESP; an abort by Reset leaves memory intact
  assign w_mem_we = (state_q == MEM_RESP) && wr_q && !w_misaligned && !Reset;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (Clk),
    .i_we    (w_mem_we),
    .i_idx   (w_idx),
    .i_wdata (wdata_q),
    .o_rdata (w_mem_rdata)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: capture -> wait out the latency -> respond
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (Req) state_d = MEM_WAIT;
      MEM_WAIT: if (cnt_q == '0) state_d = MEM_RESP;
      MEM_RESP: state_d = Req ? MEM_WAIT : MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Outputs: response fields are zero outside an unaborted RESP cycle
  always_comb begin
    Ready    = 1'b0;
    Busy     = 1'b0;
    AddrErr  = 1'b0;
    ReadData = '0;
    case (state_q)
      MEM_WAIT: Busy = 1'b1;
      MEM_RESP: begin
        if (!Reset) begin
          Ready   = 1'b1;
          AddrErr = w_misaligned;
          if (!wr_q && !w_misaligned) begin
            ReadData = w_mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign ReqDropped = req_dropped_q;

  // Request capture, latency countdown and drop detection
  always_comb begin
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    req_dropped_d = Req && (state_q == MEM_WAIT);
    if (w_accept) begin
      cnt_d   = CNT_LOAD;
      wr_d    = Wr;
      addr_d  = Address[IDX_W+1:0];
      wdata_d = WriteData;
    end else if ((state_q == MEM_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Request and flag registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      req_dropped_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      req_dropped_q <= req_dropped_d;
    end
  end

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Brief    : Scoreboard bench for mem_responder. Stimulus pushes expected
//             responses (cycle, data, error) into a queue; a monitor pops
//             and compares whenever Ready is seen. Honors MEM_ALIGN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk;
  logic        Reset, Req, Wr;
  logic [31:0] Address, WriteData, ReadData;
  logic        Ready, Busy, AddrErr, ReqDropped;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk        (clk),
    .Reset      (Reset),
    .Req        (Req),
    .Wr         (Wr),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Ready      (Ready),
    .Busy       (Busy),
    .AddrErr    (AddrErr),
    .ReqDropped (ReqDropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  bit          busy_at[int];
  bit          drop_at[int];
  logic [31:0] model_mem[DEPTH];
  int          next_accept = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a % 32'(DEPTH * 4)) / 32'd4);
  endfunction

  function automatic bit mis(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (a % 32'd4) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a request in cycle c is served iff nothing is outstanding
  // past c; its answer appears LAT+1 cycles later. Accesses are serialized,
  // so memory effects can be applied at acceptance time.
  task automatic model_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t e;
    if (c >= next_accept) begin
      for (int k = 1; k <= LAT; k++) busy_at[c + k] = 1'b1;
      next_accept = c + LAT + 1;
      e.cyc = next_accept;
      e.err = mis(a);
      if (wr) begin
        e.rdata = 32'd0;
        if (!e.err) model_mem[widx(a)] = d;
      end else begin
        e.rdata = e.err ? 32'd0 : model_mem[widx(a)];
      end
      sb.push_back(e);
    end else begin
      drop_at[c + 1] = 1'b1;
    end
  endtask

  task automatic step(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    Req = req; Wr = wr; Address = a; WriteData = d;
    if (req) model_req(wr, a, d, cyc);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
    while (cyc + 1 < next_accept) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, wr, a, d);
  endtask

  // Monitor: compare flags every cycle, pop the scoreboard on Ready
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ready;
    if (mon_en) begin
      chk("busy", 32'(Busy), 32'(busy_at.exists(cyc)));
      chk("req_dropped", 32'(ReqDropped), 32'(drop_at.exists(cyc)));
      exp_ready = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("ready", 32'(Ready), 32'(exp_ready));
      if (Ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("read_data", ReadData, e.rdata);
        chk("addr_err", 32'(AddrErr), 32'(e.err));
      end else begin
        if (!Ready) begin
          chk("idle_read_data", ReadData, 32'd0);
          chk("idle_addr_err", 32'(AddrErr), 32'd0);
        end
        if (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    logic [31:0] a;
    Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Address = 32'd0; WriteData = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_read_data", ReadData, 32'd0);
    chk("rst_addr_err", 32'(AddrErr), 32'd0);
    chk("rst_req_dropped", 32'(ReqDropped), 32'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    next_accept = cyc;
    mon_en = 1'b1;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom);

    // Write then read
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 32'd0);
    // Back-to-back write/read
    issue(1'b1, 32'h04, 32'h12345678);
    issue(1'b0, 32'h04, 32'd0);
    // Req while waiting is dropped
    issue(1'b0, 32'h08, 32'd0);
    step(1'b1, 1'b0, 32'h40, 32'd0);
    // Reset while a write waits: no response, no commit
    while (cyc + 1 < next_accept) step(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    Req = 1'b1; Wr = 1'b1; Address = 32'h20; WriteData = 32'hCAFEF00D;
    c = cyc;
    busy_at[c + 1] = 1'b1;
    @(posedge clk); #1;
    Req = 1'b0; Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    next_accept = cyc;
    issue(1'b0, 32'h20, 32'd0);
    // Aliasing modulo DEPTH*4
    issue(1'b1, 32'h100, 32'hA5A5A5A5);
    issue(1'b0, 32'h000, 32'd0);
    // Misaligned write, then read the covering word
    issue(1'b1, 32'h12, 32'h1);
    issue(1'b0, 32'h10, 32'd0);

    // Random traffic, including overlapping and misaligned requests
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      step(($urandom % 100) < 45, 1'($urandom % 2), a, $urandom);
    end

    repeat (LAT + 4) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_responder
`default_nettype wire
